instr_encoder: RTL and testbench

- Sequential instruction encoder and loader: the inverse of the opcode decoder.
- Accepts compact instruction commands (kind, rd, rs1, rs2, imm) over a valid/ready handshake.
- Builds the 32-bit RV64 word for the supported subset (R-type add/sub/and/or, addi, ld, sd, beq) and writes it into instruction memory at an auto-incrementing word address.
- Used by test harnesses and boot logic to fill imem before the core runs.

---
 rtl/riscv_pkg.sv | 44 ++++
 rtl/instr_pack.sv | 48 ++++
 rtl/instr_encoder.sv | 102 ++++++++++
 tb/tb_instr_encoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV64 encoding constants for the instruction encoder and
// the opcode decoder.
//   opcode constants, funct3/funct7 fields, command-kind encoding,
//   encoder FSM state type and a 12-bit immediate range helper.
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_DOUBLE  = 3'b011;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {
    KIND_ADD  = 3'd0,
    KIND_SUB  = 3'd1,
    KIND_AND  = 3'd2,
    KIND_OR   = 3'd3,
    KIND_ADDI = 3'd4,
    KIND_LD   = 3'd5,
    KIND_SD   = 3'd6,
    KIND_BEQ  = 3'd7
  } cmd_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } enc_state_e;

  // A 13-bit signed value fits in 12 bits when its top two bits agree.
  function automatic logic fits_imm12(input logic [12:0] imm);
    return imm[12] == imm[11];
  endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational packer from a compact command to a 32-bit RV64 word.
//   kind            in  command kind (add/sub/and/or/addi/ld/sd/beq)
//   rd, rs1, rs2    in  register fields
//   imm             in  13-bit signed immediate (beq byte offset, others 12-bit)
//   word            out encoded instruction, unused fields zero
//   illegal         out immediate out of range or misaligned branch target
module instr_pack
  import riscv_pkg::*;
(
  input  cmd_kind_e   kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind)
      KIND_ADD:  word = {F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OP_RTYPE};
      KIND_SUB:  word = {F7_SUB,  rs2, rs1, F3_ADD_SUB, rd, OP_RTYPE};
      KIND_AND:  word = {F7_BASE, rs2, rs1, F3_AND,     rd, OP_RTYPE};
      KIND_OR:   word = {F7_BASE, rs2, rs1, F3_OR,      rd, OP_RTYPE};
      KIND_ADDI: begin
        word    = {imm[11:0], rs1, F3_ADD_SUB, rd, OP_ITYPE};
        illegal = !fits_imm12(imm);
      end
      KIND_LD: begin
        word    = {imm[11:0], rs1, F3_DOUBLE, rd, OP_LOAD};
        illegal = !fits_imm12(imm);
      end
      KIND_SD: begin
        word    = {imm[11:5], rs2, rs1, F3_DOUBLE, imm[4:0], OP_STORE};
        illegal = !fits_imm12(imm);
      end
      KIND_BEQ: begin
        // B-type scatters the offset; bit 0 is implicit and must be zero.
        word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
        illegal = imm[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts compact commands over valid/ready, encodes them and
// writes them to instruction memory at an auto-incrementing word address.
//   clk, rst        clock, async active-high reset
//   clear           restart loading at address 0
//   cmd_*           command handshake and fields
//   imem_we/addr/wdata  instruction-memory write port (addr/wdata hold)
//   err             one-cycle pulse on a rejected command
//   full            every word of imem written
//   count           words written since reset/clear (saturates at depth)
//
// state | meaning
// IDLE  | ready for a command
// WRITE | strobing the encoded word into imem
// FULL  | imem filled, commands held off until clear
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_kind,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_rs1,
  input  logic [4:0]        cmd_rs2,
  input  logic [12:0]       cmd_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [31:0]       word;
  logic              illegal;
  logic              xfer;

  instr_pack u_pack (
    .kind    (cmd_kind_e'(cmd_kind)),
    .rd      (cmd_rd),
    .rs1     (cmd_rs1),
    .rs2     (cmd_rs2),
    .imm     (cmd_imm),
    .word    (word),
    .illegal (illegal)
  );

  assign xfer = cmd_valid && cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!clear && xfer && !illegal) state_d = ST_WRITE;
      ST_WRITE: state_d = (!clear && ptr_q == '1) ? ST_FULL : ST_IDLE;
      ST_FULL:  if (clear) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // rst gates ready so nothing can be accepted while reset is held.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE) && !clear && !rst;
    imem_we   = (state_q == ST_WRITE);
    full      = (state_q == ST_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      count      <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      err        <= 1'b0;
    end else begin
      err <= xfer && illegal;
      if (xfer && !illegal) begin
        imem_addr  <= ptr_q;
        imem_wdata <= word;
      end
      // A clear during WRITE lets the strobe finish but wins over the increment.
      if (clear) begin
        ptr_q <= '0;
        count <= '0;
      end else if (state_q == ST_WRITE) begin
        ptr_q <= ptr_q + 1'b1;
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_kind = '0;
  logic [4:0]    cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic [12:0]   cmd_imm = '0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          err;
  logic          full;
  logic [AW:0]   count;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic [AW-1:0] exp_ptr = '0;
  int            exp_count = 0;
  bit            exp_full = 1'b0;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_kind   (cmd_kind),
    .cmd_rd     (cmd_rd),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_imm    (cmd_imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .err        (err),
    .full       (full),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard side: every observed write must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      if (sb.size() == 0) begin
        chk("unexpected_we", {31'd0, imem_we}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", {30'd0, imem_addr}, {30'd0, e.addr});
        chk("wr_data", imem_wdata, e.data);
      end
    end
  end

  task automatic send(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [12:0] imm,
                      input logic [31:0] exp_word, input bit legal, input bit clr_in_write);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
      return;
    end
    cmd_kind = k; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_valid = 1'b1;
    if (legal) sb.push_back(exp_t'{exp_ptr, exp_word});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    if (legal) begin
      chk("ready_low", {31'd0, cmd_ready}, 32'd0);
      chk("we_high", {31'd0, imem_we}, 32'd1);
      chk("no_err", {31'd0, err}, 32'd0);
      if (clr_in_write) clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      if (clr_in_write) begin
        exp_ptr = '0; exp_count = 0; exp_full = 1'b0;
      end else begin
        exp_count++;
        exp_full = (exp_ptr == '1);
        exp_ptr = exp_ptr + 1'b1;
      end
      #1;
      chk("ready_back", {31'd0, cmd_ready}, {31'd0, !exp_full});
      chk("full", {31'd0, full}, {31'd0, exp_full});
      chk("count", {29'd0, count}, exp_count);
      chk("we_low", {31'd0, imem_we}, 32'd0);
    end else begin
      chk("err_high", {31'd0, err}, 32'd1);
      chk("ready_hold", {31'd0, cmd_ready}, 32'd1);
      chk("we_never", {31'd0, imem_we}, 32'd0);
      @(negedge clk);
      chk("err_pulse", {31'd0, err}, 32'd0);
      chk("count_keep", {29'd0, count}, exp_count);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1 chk("clear_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    clear = 1'b0;
    exp_ptr = '0; exp_count = 0; exp_full = 1'b0;
    #1;
    chk("clear_full", {31'd0, full}, 32'd0);
    chk("clear_count", {29'd0, count}, 32'd0);
    chk("clear_ready_back", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd0);
    chk({tag, "_we"}, {31'd0, imem_we}, 32'd0);
    chk({tag, "_addr"}, {30'd0, imem_addr}, 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_full"}, {31'd0, full}, 32'd0);
    chk({tag, "_count"}, {29'd0, count}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    send(3'd4, 5'd1, 5'd0, 5'd0, 13'd5,    32'h00500093, 1'b1, 1'b0); // addi x1,x0,5
    send(3'd0, 5'd3, 5'd1, 5'd2, 13'd0,    32'h002081B3, 1'b1, 1'b0); // add x3,x1,x2
    send(3'd1, 5'd3, 5'd1, 5'd2, 13'd0,    32'h402081B3, 1'b1, 1'b0); // sub x3,x1,x2
    send(3'd7, 5'd0, 5'd1, 5'd2, 13'd3,    32'h0,        1'b0, 1'b0); // beq misaligned
    send(3'd4, 5'd1, 5'd0, 5'd0, 13'h0800, 32'h0,        1'b0, 1'b0); // addi +2048
    send(3'd6, 5'd0, 5'd1, 5'd2, 13'd8,    32'h0020B423, 1'b1, 1'b0); // sd x2,8(x1)

    // Full: a further command must be held off with no write.
    cmd_kind = 3'd4; cmd_rd = 5'd1; cmd_imm = 13'd1; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("held_ready", {31'd0, cmd_ready}, 32'd0);
      chk("held_full", {31'd0, full}, 32'd1);
    end
    cmd_valid = 1'b0;
    chk("full_count", {29'd0, count}, 32'd4);
    do_clear();

    send(3'd5, 5'd5, 5'd1, 5'd0, 13'h1FFC, 32'hFFC0B283, 1'b1, 1'b0); // ld x5,-4(x1)
    send(3'd7, 5'd0, 5'd1, 5'd2, 13'h1FF8, 32'hFE208CE3, 1'b1, 1'b0); // beq x1,x2,-8
    send(3'd2, 5'd4, 5'd5, 5'd6, 13'd0,    32'h0062F233, 1'b1, 1'b0); // and x4,x5,x6
    send(3'd3, 5'd7, 5'd8, 5'd9, 13'd0,    32'h009463B3, 1'b1, 1'b0); // or x7,x8,x9
    do_clear();

    send(3'd4, 5'd1, 5'd1, 5'd0, 13'h1800, 32'h80008093, 1'b1, 1'b0); // addi -2048
    send(3'd7, 5'd0, 5'd0, 5'd0, 13'h0FFE, 32'h7E000FE3, 1'b1, 1'b1); // beq +4094, clear in WRITE
    send(3'd7, 5'd0, 5'd0, 5'd0, 13'h1000, 32'h80000063, 1'b1, 1'b0); // beq -4096 lands at 0

    // Reset during WRITE.
    cmd_kind = 3'd0; cmd_rd = 5'd3; cmd_rs1 = 5'd1; cmd_rs2 = 5'd2; cmd_imm = '0;
    chk("pre_rst_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    sb.push_back(exp_t'{exp_ptr, 32'h002081B3});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_we", {31'd0, imem_we}, 32'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("midwrite_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
